inpass_n_frame_config: RTL and testbench



---
 rtl/inpass_n_frame_config.sv | 127 ++++++++++++
 tb/tb_inpass_n_frame_config.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inpass_n_frame_config.sv
// N-channel fabric input pass with per-channel comb/reg/sync/pulse modes.
// Optional mode-10 deglitch filter is enabled by INPASS_DEGLITCH_EN.
module my_mux2 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);
  assign X = S ? A1 : A0;
endmodule

module inpass_n_frame_config #(
  parameter int NUM_CH          = 8,
  parameter int NoConfigBits    = 16,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  if (NoConfigBits != 2*NUM_CH) begin : g_cfg_chk
    $error("NoConfigBits must equal 2*NUM_CH");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_ch_chk
    $error("NUM_CH must be in 1..32");
  end

  logic [NUM_CH-1:0] s1_q, s1_d;
  logic [NUM_CH-1:0] s2_q, s2_d;
  logic [NUM_CH-1:0] s3_q, s3_d;
  logic [NUM_CH-1:0] sync_w;
  logic [NUM_CH-1:0] pulse_w;

  always_comb begin
    s1_d = I;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Flops run in every mode so reconfiguration needs no flush.
  always_ff @(posedge UserCLK or posedge UserRST) begin
    if (UserRST) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulse_w = s2_q & ~s3_q;

`ifdef INPASS_DEGLITCH_EN
  if (DEGLITCH_CYCLES < 2) begin : g_dg_chk
    $error("DEGLITCH_CYCLES must be >= 2");
  end

  localparam int CW = $clog2(DEGLITCH_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEGLITCH_CYCLES - 1);

  logic [NUM_CH-1:0] f_q, f_d;
  logic [CW-1:0]     c_q [NUM_CH];
  logic [CW-1:0]     c_d [NUM_CH];

  // Accept s2 only after it has differed from f for DEGLITCH_CYCLES edges.
  always_comb begin
    f_d = f_q;
    for (int k = 0; k < NUM_CH; k++) begin
      c_d[k] = c_q[k];
      if (s2_q[k] == f_q[k]) begin
        c_d[k] = '0;
      end else if (c_q[k] == CMAX) begin
        f_d[k] = s2_q[k];
        c_d[k] = '0;
      end else begin
        c_d[k] = c_q[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge UserCLK or posedge UserRST) begin
    if (UserRST) begin
      f_q <= '0;
      for (int k = 0; k < NUM_CH; k++) c_q[k] <= '0;
    end else begin
      f_q <= f_d;
      for (int k = 0; k < NUM_CH; k++) c_q[k] <= c_d[k];
    end
  end

  assign sync_w = f_q;
`else
  assign sync_w = s2_q;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic lo_w;
    logic hi_w;

    my_mux2 u_lo (
      .A0 (I[k]),
      .A1 (s1_q[k]),
      .S  (ConfigBits[2*k]),
      .X  (lo_w)
    );

    my_mux2 u_hi (
      .A0 (sync_w[k]),
      .A1 (pulse_w[k]),
      .S  (ConfigBits[2*k]),
      .X  (hi_w)
    );

    my_mux2 u_out (
      .A0 (lo_w),
      .A1 (hi_w),
      .S  (ConfigBits[2*k+1]),
      .X  (O[k])
    );
  end

endmodule

// File: tb/tb_inpass_n_frame_config.sv
// Directed bench for inpass_n_frame_config, 4 channels.
// Mode-10 expectations follow INPASS_DEGLITCH_EN when defined.
module tb_inpass_n_frame_config;

  localparam int SL =
`ifdef INPASS_DEGLITCH_EN
    6;
`else
    2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_v;
  logic [7:0] cfg;
  logic [3:0] out_v;

  int n_vec = 0;
  int n_err = 0;
  int npulse;

  bit iv [12];
  bit ov [12];

  always #5 clk = ~clk;

  inpass_n_frame_config #(
    .NUM_CH          (4),
    .NoConfigBits    (8),
    .DEGLITCH_CYCLES (4)
  ) dut (
    .UserCLK    (clk),
    .UserRST    (rst),
    .I          (in_v),
    .O          (out_v),
    .ConfigBits (cfg)
  );

  task automatic check(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] ival);
    in_v = ival;
    rst  = 1'b1;
    step();
    step();
    rst  = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    in_v = 4'h0;
    cfg  = 8'b11_10_01_00;
    #1;
    check("rst_idle", out_v, 4'b0000);
    in_v = 4'b0101;
    #1;
    check("rst_comb", out_v, 4'b0001);

    // Latency of each mode after a step on all inputs
    do_reset(4'h0);
    in_v = 4'hF;
    #1;
    check("lat_e0", out_v, 4'b0001);
    for (int n = 1; n <= 7; n++) begin
      step();
      check($sformatf("lat_e%0d", n), out_v,
            {n == 2, n >= SL, n >= 1, 1'b1});
    end

    // Async reset with all channels registered
    cfg = 8'b01_01_01_01;
    do_reset(4'h0);
    in_v = 4'hF;
    step();
    step();
    check("reg_high", out_v, 4'hF);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", out_v, 4'h0);
    cfg  = 8'b01_01_01_00;
    in_v = 4'b1110;
    #1;
    check("rst_c0_lo", out_v, 4'b0000);
    in_v = 4'b0001;
    #1;
    check("rst_c0_hi", out_v, 4'b0001);

    // Rising-edge pulse mode, 3-cycle levels
    cfg = 8'hFF;
    do_reset(4'h0);
    step();
    step();
    iv = '{1,1,1,0,0,0,1,1,1,1,1,1};
    ov = '{0,1,0,0,0,0,0,1,0,0,0,0};
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      in_v = {4{iv[i]}};
      step();
      if (out_v[0]) npulse++;
      check($sformatf("pulse_e%0d", i + 1), out_v, {4{ov[i]}});
    end
    check("pulse_cnt", 4'(npulse), 4'd2);

    // Release with input already high
    cfg = 8'b00_00_01_11;
    do_reset(4'hF);
    #1;
    check("hi_rel_e0", out_v, 4'b1100);
    step();
    check("hi_rel_e1", out_v, 4'b1110);
    step();
    check("hi_rel_e2", out_v, 4'b1111);
    step();
    check("hi_rel_e3", out_v, 4'b1110);
    step();
    check("hi_rel_e4", out_v, 4'b1110);

    // Switch ch1 from registered to synchronised mid-stream
    for (int i = 0; i < 4; i++) step();
    cfg = 8'b00_00_10_11;
    #1;
    check("sw_now", out_v, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sw_e%0d", i + 1), out_v, 4'b1110);
    end

    // Synchronised mode against short and long pulses
    cfg = 8'b10_10_10_10;
    do_reset(4'h0);
    step();
    step();
`ifdef INPASS_DEGLITCH_EN
    iv = '{1,1,1,0,0,0,0,0,0,0,0,0};
    ov = '{0,0,0,0,0,0,0,0,0,0,0,0};
`else
    iv = '{1,0,0,0,0,0,0,0,0,0,0,0};
    ov = '{0,1,0,0,0,0,0,0,0,0,0,0};
`endif
    for (int i = 0; i < 12; i++) begin
      in_v = {4{iv[i]}};
      step();
      check($sformatf("short_e%0d", i + 1), out_v, {4{ov[i]}});
    end
`ifdef INPASS_DEGLITCH_EN
    iv = '{1,1,1,1,0,0,0,0,0,0,0,0};
    ov = '{0,0,0,0,0,1,1,1,1,0,0,0};
`else
    iv = '{1,1,1,1,0,0,0,0,0,0,0,0};
    ov = '{0,1,1,1,1,0,0,0,0,0,0,0};
`endif
    for (int i = 0; i < 12; i++) begin
      in_v = {4{iv[i]}};
      step();
      check($sformatf("long_e%0d", i + 1), out_v, {4{ov[i]}});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
